// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: orders exception, memory
// wait, mult/div interlock, load-use stall and branch squash into stage enables.
module pipeline_sequencer #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             md_use,
    input  logic             dmem_ready,
    input  logic             exception,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MDW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        EXC_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [MDW-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic pc_w, ifid_w, ifid_f, idex_b, idex_f, hold;

    always_comb begin
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        ifid_f  = 1'b0;
        idex_b  = 1'b0;
        idex_f  = 1'b0;
        hold    = 1'b0;
        state_d = RUN;
        priority case (1'b1)
            exception: begin
                ifid_f  = 1'b1;
                idex_f  = 1'b1;
                state_d = EXC_FLUSH;
            end
            (state_q == EXC_FLUSH): begin
                ifid_f = 1'b1;
            end
            !dmem_ready: begin
                pc_w    = 1'b0;
                ifid_w  = 1'b0;
                hold    = 1'b1;
                state_d = MEM_WAIT;
            end
            (md_busy && (md_use || md_start)): begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                idex_b = 1'b1;
            end
            hazard_stall: begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                idex_b = 1'b1;
            end
            branch_taken: begin
                ifid_f = 1'b1;
            end
            default: ;
        endcase
    end

    // A new start outranks the decrement, so completion+start reloads cleanly.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (exception) begin
            md_cnt_d = '0;
        end else if (md_start && pc_w && !idex_b) begin
            md_cnt_d = MD_LOAD;
        end else if (md_busy && !hold) begin
            md_cnt_d = md_cnt_q - MDW'(1);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_w && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            stall_q  <= stall_d;
        end
    end

    // Every enable is forced low while reset is asserted.
    assign pc_write     = rst_n & pc_w;
    assign ifid_write   = rst_n & ifid_w;
    assign ifid_flush   = rst_n & ifid_f;
    assign idex_bubble  = rst_n & idex_b;
    assign idex_flush   = rst_n & idex_f;
    assign exmem_hold   = rst_n & hold;
    assign md_busy      = (md_cnt_q != '0);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed scoreboard bench for pipeline_sequencer; a narrow-counter
// second instance exercises stall counter saturation.
module tb_pipeline_sequencer;

    logic clk;
    logic rst_n;
    logic hazard_stall, branch_taken, md_start, md_use;
    logic dmem_ready, exception;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic        idex_flush, exmem_hold, md_busy;
    logic [15:0] stall_cycles;

    logic        s_pc, s_ifw, s_iff, s_bub, s_idf, s_hold, s_busy;
    logic [3:0]  s_stall;

    pipeline_sequencer #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .md_start(md_start), .md_use(md_use),
        .dmem_ready(dmem_ready), .exception(exception),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .idex_flush(idex_flush), .exmem_hold(exmem_hold),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    pipeline_sequencer #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .md_start(md_start), .md_use(md_use),
        .dmem_ready(dmem_ready), .exception(exception),
        .pc_write(s_pc), .ifid_write(s_ifw),
        .ifid_flush(s_iff), .idex_bubble(s_bub),
        .idex_flush(s_idf), .exmem_hold(s_hold),
        .md_busy(s_busy), .stall_cycles(s_stall)
    );

    typedef struct {
        int         id;
        logic [6:0] o;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // in = {exception, dmem_ready, md_start, md_use, hazard, branch}
    // e  = {pc, ifid_w, ifid_f, bubble, idex_f, hold, busy}
    task automatic cyc(input logic rst, input logic [5:0] in,
                       input logic [6:0] e, input int c);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n        = rst;
        exception    = in[5];
        dmem_ready   = in[4];
        md_start     = in[3];
        md_use       = in[2];
        hazard_stall = in[1];
        branch_taken = in[0];
        x.id  = vec_id;
        x.o   = e;
        x.cnt = c;
        q.push_back(x);
        vec_id++;
    endtask

    initial begin : monitor
        exp_t       x;
        logic [6:0] got;
        int         sat;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x   = q.pop_front();
                got = {pc_write, ifid_write, ifid_flush, idex_bubble,
                       idex_flush, exmem_hold, md_busy};
                sat = (x.cnt > 15) ? 15 : x.cnt;
                checks++;
                if (got !== x.o) begin
                    errors++;
                    $display("FAIL ctrl vec %0d: got %b want %b",
                             x.id, got, x.o);
                end
                checks++;
                if (stall_cycles !== 16'(x.cnt)) begin
                    errors++;
                    $display("FAIL stall_cycles vec %0d: got %0d want %0d",
                             x.id, stall_cycles, x.cnt);
                end
                checks++;
                if (s_stall !== 4'(sat)) begin
                    errors++;
                    $display("FAIL sat_count vec %0d: got %0d want %0d",
                             x.id, s_stall, sat);
                end
            end
        end
    end

    initial begin : driver
        int n;
        rst_n        = 1'b0;
        exception    = 1'b0;
        dmem_ready   = 1'b1;
        md_start     = 1'b0;
        md_use       = 1'b0;
        hazard_stall = 1'b0;
        branch_taken = 1'b0;

        cyc(1'b0, 6'b010000, 7'b0000000, 0);
        cyc(1'b1, 6'b010000, 7'b1100000, 0);
        // single hazard stall
        cyc(1'b1, 6'b010010, 7'b0001000, 0);
        cyc(1'b1, 6'b010000, 7'b1100000, 1);
        // mult/div start then dependent mfhi: 3 bubbles
        cyc(1'b1, 6'b011000, 7'b1100000, 1);
        cyc(1'b1, 6'b010100, 7'b0001001, 1);
        cyc(1'b1, 6'b010100, 7'b0001001, 2);
        cyc(1'b1, 6'b010100, 7'b0001001, 3);
        cyc(1'b1, 6'b010100, 7'b1100000, 4);
        // memory wait over a hazard, then the hazard bubble
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 6'b000010, 7'b0000010, 4 + i);
        cyc(1'b1, 6'b010010, 7'b0001000, 9);
        // branch under stall, then squash
        cyc(1'b1, 6'b010011, 7'b0001000, 10);
        cyc(1'b1, 6'b010001, 7'b1110000, 11);
        // exception while md busy and memory waiting
        cyc(1'b1, 6'b011000, 7'b1100000, 11);
        cyc(1'b1, 6'b000000, 7'b0000011, 11);
        cyc(1'b1, 6'b100000, 7'b1110101, 12);
        cyc(1'b1, 6'b010000, 7'b1110000, 12);
        cyc(1'b1, 6'b010000, 7'b1100000, 12);
        // push narrow counter past saturation
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 6'b010010, 7'b0001000, 12 + i);
        cyc(1'b1, 6'b010000, 7'b1100000, 16);
        cyc(1'b1, 6'b010010, 7'b0001000, 16);
        cyc(1'b1, 6'b010000, 7'b1100000, 17);
        // reset while md busy
        cyc(1'b1, 6'b011000, 7'b1100000, 17);
        cyc(1'b1, 6'b010000, 7'b1100001, 17);
        cyc(1'b0, 6'b010000, 7'b0000000, 0);
        cyc(1'b1, 6'b010000, 7'b1100000, 0);
        cyc(1'b1, 6'b010100, 7'b1100000, 0);

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. Combines the load-use/branch hazard stall, ID-stage branch/jump redirects, data-memory wait and a multi-cycle mult/div unit. Produces per-stage write enables, flush and bubble controls, and a stall-cycle performance counter. Sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX and EX/MEM register enables.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit is busy after a start (≥2)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
hazard_stall  input  1  load-use/branch-operand stall from hazard detection unit
branch_taken  input  1  ID-stage branch resolved taken or jump, redirect PC
md_start  input  1  ID-stage instruction is mult/div (issues to EX this cycle if not stalled)
md_use  input  1  ID-stage instruction reads HI/LO (mfhi/mflo)
dmem_ready  input  1  data memory completes access this cycle (held high when no access)
exception  input  1  EX-stage exception, redirect to handler
pc_write  output  1  PC register write enable
ifid_write  output  1  IF/ID register write enable
ifid_flush  output  1  zero IF/ID instruction (insert nop)
idex_bubble  output  1  zero ID/EX control lines
idex_flush  output  1  zero ID/EX entirely (exception)
exmem_hold  output  1  hold EX/MEM and MEM/WB (freeze back end)
md_busy  output  1  mult/div unit busy
stall_cycles  output  CNT_W  saturating count of cycles with pc_write low

Behaviour:
- Reset (rst_n low, async): FSM=RUN, md counter=0, md_busy=0, stall_cycles=0. Outputs during reset: pc_write=0, ifid_write=0, all flush/bubble/hold=0.
- FSM states: RUN, MEM_WAIT, EXC_FLUSH. The mult/div counter is independent of the FSM.
- Per-cycle priority (combinational, from current inputs and state): exception > memory wait > md interlock > hazard_stall > branch_taken.
- exception=1 (any state): pc_write=1, ifid_flush=1, idex_flush=1, exmem_hold=0. Next state EXC_FLUSH. Clear md counter (md_busy=0 next cycle).
- EXC_FLUSH: one cycle. ifid_flush=1, pc_write=1, ifid_write=1. Clears the instruction fetched from the old path. Next state RUN.
- dmem_ready=0 while in RUN or MEM_WAIT: pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0. The whole pipe freezes. Next state MEM_WAIT. Return to RUN in the cycle dmem_ready=1; that cycle behaves as RUN.
- md interlock: md_busy=1 and (md_use=1 or md_start=1) → pc_write=0, ifid_write=0, idex_bubble=1.
- hazard_stall=1 → pc_write=0, ifid_write=0, idex_bubble=1.
- branch_taken=1 with no higher condition → pc_write=1, ifid_write=1, ifid_flush=1 (one-slot squash).
- Otherwise: pc_write=1, ifid_write=1, others 0.
- md counter:
  - Loads MD_LATENCY-1 on a clock edge where md_start=1 and the instruction advances (pc_write=1, no bubble, no exception).
  - Decrements while nonzero and exmem_hold=0. Holds during a memory freeze.
  - md_busy = (counter≠0).
  - Completion and a new start in the same cycle: the new load wins.
- stall_cycles: increments on each clock edge with rst_n high and pc_write=0. Saturates at all-ones, no wrap.
- Outputs are combinational from state and inputs. There is zero-cycle latency from input to control.

Test Plan:
- Reset mid-MD_WAIT (md counter=10), assert rst_n=0 → md_busy=0, stall_cycles=0, and pc_write=1 on the first cycle after release.
- hazard_stall=1 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 that cycle. Next cycle all enables 1. stall_cycles=1.
- md_start then md_use on the next instruction, MD_LATENCY=4 → md_use stalled for exactly 3 cycles (idex_bubble=1). It advances when md_busy falls.
- dmem_ready=0 for 5 cycles while hazard_stall=1 → exmem_hold=1 and idex_bubble=0 for all 5 cycles. Then the hazard bubble follows.
- branch_taken=1 with hazard_stall=1 → stall only (ifid_flush=0). The next cycle with hazard_stall=0 gives ifid_flush=1, pc_write=1.
- exception=1 during md_busy and dmem_ready=0 → idex_flush=1, ifid_flush=1, pc_write=1. The next cycle gives ifid_flush=1 and md_busy=0. Also force stall_cycles to 0xFFFE and stall 3 cycles → value held at 0xFFFF.
